count_ones_ctrl: RTL and testbench

//   Control FSM that drives count_ones_datapath. It accepts a go request,

---
 rtl/count_ones_ctrl_if.sv | 40 ++++
 rtl/count_ones_ctrl.sv | 103 ++++++++++
 tb/tb_count_ones_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_ones_ctrl_if.sv
// -----------------------------------------------------------------------------
// count_ones_ctrl_if
//   Control/status bundle between count_ones_ctrl and its neighbours.
//   The slave side is the controller; the master side supplies go and the
//   datapath status and consumes the control outputs.
//
//   go         start request, level
//   n_eq_0     datapath status: operand register == 0
//   n_en       datapath operand register update enable
//   n_sel      1: load input word, 0: n & (n-1)
//   count_en   datapath count update enable
//   count_sel  1: clear count (used with count_en)
//   out_en     datapath drives count on out when 1
//   done       result valid, held until next accepted go
//   cycles     COMPUTE cycles of last run (valid while done=1)
// -----------------------------------------------------------------------------
interface count_ones_ctrl_if #(
    parameter int INPUT_WIDTH = 32,
    parameter int CYC_WIDTH   = $clog2(INPUT_WIDTH + 3)
);
    logic                 go;
    logic                 n_eq_0;
    logic                 n_en;
    logic                 n_sel;
    logic                 count_en;
    logic                 count_sel;
    logic                 out_en;
    logic                 done;
    logic [CYC_WIDTH-1:0] cycles;

    modport master (
        output go, n_eq_0,
        input  n_en, n_sel, count_en, count_sel, out_en, done, cycles
    );

    modport slave (
        input  go, n_eq_0,
        output n_en, n_sel, count_en, count_sel, out_en, done, cycles
    );
endinterface

// File: rtl/count_ones_ctrl.sv
// -----------------------------------------------------------------------------
// count_ones_ctrl
//   Control FSM for the count_ones datapath. Accepts a go request, loads the
//   operand and clears the count, then clears the lowest set bit every cycle
//   until the datapath reports n_eq_0. The result is then flagged with
//   done/out_en and the number of COMPUTE iterations is reported on cycles.
//   A new run needs go to drop and rise again.
//
//   clk   in  clock, rising edge
//   rst   in  synchronous, active-high reset
//   bus   slave modport of count_ones_ctrl_if (go/n_eq_0 in, controls out)
// -----------------------------------------------------------------------------
module count_ones_ctrl #(
    parameter int INPUT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    count_ones_ctrl_if.slave   bus
);
    localparam int CYC_WIDTH = $clog2(INPUT_WIDTH + 3);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPUTE  = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CYC_WIDTH-1:0] cnt_q, cnt_d;
    logic [CYC_WIDTH-1:0] cycles_q, cycles_d;
    logic                 done_q, done_d;

    logic n_en_c, n_sel_c, count_en_c, count_sel_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cycles_d    = cycles_q;
        n_en_c      = 1'b0;
        n_sel_c     = 1'b0;
        count_en_c  = 1'b0;
        count_sel_c = 1'b0;

        case (state_q)
            IDLE, WAIT_LOW: begin
                if (bus.go) begin
                    n_en_c      = 1'b1;
                    n_sel_c     = 1'b1;
                    count_en_c  = 1'b1;
                    count_sel_c = 1'b1;
                    cnt_d       = '0;
                    state_d     = COMPUTE;
                end
            end
            COMPUTE: begin
                if (!bus.n_eq_0) begin
                    n_en_c = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cycles_d = cnt_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!bus.go) begin
                    state_d = WAIT_LOW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done/out_en come from a register loaded with the next-state decode,
    // so they track DONE/WAIT_LOW with no combinational path from go.
    assign done_d = (state_d == DONE) || (state_d == WAIT_LOW);

    // Mealy controls are held off while rst is asserted so the datapath
    // never sees a load during reset.
    assign bus.n_en      = n_en_c      & ~rst;
    assign bus.n_sel     = n_sel_c     & ~rst;
    assign bus.count_en  = count_en_c  & ~rst;
    assign bus.count_sel = count_sel_c & ~rst;
    assign bus.done      = done_q;
    assign bus.out_en    = done_q;
    assign bus.cycles    = cycles_q;
endmodule

// File: tb/tb_count_ones_ctrl.sv
module tb_count_ones_ctrl;
    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic [31:0] dp_n;
    logic [5:0]  dp_cnt;
    logic [5:0]  dp_out;
    int          checks;
    int          errors;

    count_ones_ctrl_if #(.INPUT_WIDTH(32)) bus ();

    count_ones_ctrl #(.INPUT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference datapath: operand register, bit counter, gated output.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_n   <= '0;
            dp_cnt <= '0;
        end else begin
            if (bus.n_en) dp_n <= bus.n_sel ? din : (dp_n & (dp_n - 32'd1));
            if (bus.count_en && bus.count_sel) dp_cnt <= '0;
            else if (bus.n_en && !bus.n_sel)   dp_cnt <= dp_cnt + 6'd1;
        end
    end
    assign bus.n_eq_0 = (dp_n == 32'd0);
    assign dp_out     = bus.out_en ? dp_cnt : 6'd0;

    // mode 0: go pulsed for one clock, 1: go held, 2: go random during COMPUTE.
    // lat counts clock edges from the one that samples go until done reads 1.
    task automatic do_run(input logic [31:0] d, input int mode,
                          output int lat, output int nen, output logic d1);
        din    = d;
        bus.go = 1'b1;
        lat    = 0;
        nen    = 0;
        d1     = 1'bx;
        while (lat < 100) begin
            @(negedge clk);
            if (bus.n_en) nen++;
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) d1 = bus.done;
            if (mode == 0) bus.go = 1'b0;
            else if (mode == 2) bus.go = 1'($urandom_range(0, 1));
            if (bus.done) break;
        end
        if (mode == 2) bus.go = 1'b0;
    endtask

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        int lat, nen;
        logic d1;
        // reset at idle with go high during reset
        rst = 1'b1; bus.go = 1'b1; din = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (bus.n_en !== 1'b0) begin errors++; $display("FAIL rst_n_en got %b exp 0", bus.n_en); end
        clocks(2);
        bus.go = 1'b0;
        rst = 1'b0;
        clocks(1);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_idle_done got %b exp 0", bus.done); end
        checks++;
        if (bus.out_en !== 1'b0) begin errors++; $display("FAIL rst_idle_out_en got %b exp 0", bus.out_en); end
        checks++;
        if (bus.cycles !== 6'd0) begin errors++; $display("FAIL rst_idle_cycles got %0d exp 0", bus.cycles); end
        checks++;
        if (dp_out !== 6'd0) begin errors++; $display("FAIL rst_idle_out got %0d exp 0", dp_out); end
        // reset mid-COMPUTE
        din = 32'hFFFF_FFFF; bus.go = 1'b1;
        clocks(1);
        bus.go = 1'b0;
        clocks(5);
        rst = 1'b1;
        clocks(2);
        rst = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.out_en !== 1'b0 || dp_out !== 6'd0)
            begin errors++; $display("FAIL rst_mid done=%b out_en=%b out=%0d exp 0/0/0", bus.done, bus.out_en, dp_out); end
        clocks(3);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_stay_idle done got %b exp 0", bus.done); end
        // reset while showing a result
        do_run(32'h0000_0007, 0, lat, nen, d1);
        rst = 1'b1;
        clocks(2);
        rst = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || dp_out !== 6'd0 || bus.cycles !== 6'd0)
            begin errors++; $display("FAIL rst_done done=%b out=%0d cycles=%0d exp 0/0/0", bus.done, dp_out, bus.cycles); end
    endtask

    task automatic test_zero;
        int lat, nen;
        logic d1;
        do_run(32'h0000_0000, 0, lat, nen, d1);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL zero_latency got %0d exp 2", lat); end
        checks++;
        if (dp_out !== 6'd0) begin errors++; $display("FAIL zero_out got %0d exp 0", dp_out); end
        checks++;
        if (bus.cycles !== 6'd0) begin errors++; $display("FAIL zero_cycles got %0d exp 0", bus.cycles); end
        clocks(2);
    endtask

    task automatic test_five_bits;
        int lat, nen;
        logic d1;
        do_run(32'hF000_0001, 0, lat, nen, d1);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL five_latency got %0d exp 7", lat); end
        checks++;
        if (dp_out !== 6'd5) begin errors++; $display("FAIL five_out got %0d exp 5", dp_out); end
        checks++;
        if (bus.cycles !== 6'd5) begin errors++; $display("FAIL five_cycles got %0d exp 5", bus.cycles); end
        checks++;
        if (nen !== 6) begin errors++; $display("FAIL five_n_en_cycles got %0d exp 6", nen); end
        clocks(2);
    endtask

    task automatic test_hold_and_restart;
        int lat, nen;
        logic d1;
        do_run(32'hFFFF_FFFF, 1, lat, nen, d1);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL hold_latency got %0d exp 34", lat); end
        checks++;
        if (dp_out !== 6'd32) begin errors++; $display("FAIL hold_out got %0d exp 32", dp_out); end
        checks++;
        if (bus.cycles !== 6'd32) begin errors++; $display("FAIL hold_cycles got %0d exp 32", bus.cycles); end
        din = 32'h0000_0001;
        nen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.n_en) nen++;
        end
        #1;
        checks++;
        if (nen !== 0) begin errors++; $display("FAIL hold_no_restart n_en cycles got %0d exp 0", nen); end
        checks++;
        if (bus.done !== 1'b1 || dp_out !== 6'd32)
            begin errors++; $display("FAIL hold_visible done=%b out=%0d exp 1/32", bus.done, dp_out); end
        bus.go = 1'b0;
        clocks(2);
        checks++;
        if (bus.done !== 1'b1 || dp_out !== 6'd32)
            begin errors++; $display("FAIL wait_low_visible done=%b out=%0d exp 1/32", bus.done, dp_out); end
        do_run(32'h0000_0008, 0, lat, nen, d1);
        checks++;
        if (d1 !== 1'b0) begin errors++; $display("FAIL restart_done_drop got %b exp 0", d1); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL restart_latency got %0d exp 3", lat); end
        checks++;
        if (dp_out !== 6'd1) begin errors++; $display("FAIL restart_out got %0d exp 1", dp_out); end
        clocks(2);
    endtask

    task automatic test_go_toggle;
        int lat, nen;
        logic d1;
        do_run(32'h0F0F_0F0F, 2, lat, nen, d1);
        checks++;
        if (lat !== 18) begin errors++; $display("FAIL toggle_latency got %0d exp 18", lat); end
        checks++;
        if (dp_out !== 6'd16) begin errors++; $display("FAIL toggle_out got %0d exp 16", dp_out); end
        checks++;
        if (bus.cycles !== 6'd16) begin errors++; $display("FAIL toggle_cycles got %0d exp 16", bus.cycles); end
        clocks(2);
    endtask

    task automatic test_random;
        int lat, nen, k;
        logic d1;
        logic [31:0] d;
        for (int r = 0; r < 1000; r++) begin
            d = $urandom;
            case (r % 4)
                0: d = d & $urandom;
                1: d = d | $urandom;
                default: ;
            endcase
            k = $countones(d);
            do_run(d, 0, lat, nen, d1);
            checks++;
            if (lat !== k + 2) begin errors++; $display("FAIL rand_latency in=%h got %0d exp %0d", d, lat, k + 2); end
            checks++;
            if (dp_out !== 6'(k)) begin errors++; $display("FAIL rand_out in=%h got %0d exp %0d", d, dp_out, k); end
            checks++;
            if (bus.cycles !== 6'(k)) begin errors++; $display("FAIL rand_cycles in=%h got %0d exp %0d", d, bus.cycles, k); end
            clocks($urandom_range(1, 4));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.go = 1'b0;
        din    = '0;
        clocks(1);
        test_reset();
        test_zero();
        test_five_bits();
        test_hold_and_restart();
        test_go_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
